// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit FIFO between two byte-burst clients.
// Define UART_ARB_HDR_EN to prefix each burst with a {3'b101, id, len} header byte.
module uart_tx_arbiter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       data0,
  input  logic [7:0]       data1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [1:0]       gnt,
  output logic             busy,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       w_data
);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEND, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             id;
  logic             wr_c;
  logic [7:0]       byte_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign id = gnt_q[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_c    = 1'b0;
    byte_c  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the client that did not win last time is granted
          if (req0 && (!req1 || last_q)) begin
            gnt_d = 2'b01;
            cnt_d = len0;
          end else begin
            gnt_d = 2'b10;
            cnt_d = len1;
          end
`ifdef UART_ARB_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        wr_c   = !tx_full;
        byte_c = 8'({3'b101, id, cnt_q});
        if (wr_c) state_d = S_SEND;
      end
`endif
      S_SEND: begin
        wr_c   = !tx_full;
        byte_c = gnt_q[0] ? data0 : (gnt_q[1] ? data1 : 8'h00);
        if (wr_c) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      S_DONE: begin
        last_d  = id;
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writes are blocked in any cycle reset is high so an abandoned burst cannot leak a byte
  assign wr_uart = wr_c && !reset;
  assign w_data  = reset ? 8'h00 : byte_c;
  assign ack0    = wr_uart && (state_q == S_SEND) && gnt_q[0];
  assign ack1    = wr_uart && (state_q == S_SEND) && gnt_q[1];
  assign done0   = !reset && (state_q == S_DONE) && gnt_q[0];
  assign done1   = !reset && (state_q == S_DONE) && gnt_q[1];
  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: clients modelled as byte queues, output stream checked
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [LEN_W-1:0] len0, len1;
  logic [7:0]       data0, data1;
  logic             ack0, ack1, done0, done1;
  logic [1:0]       gnt;
  logic             busy;
  logic             tx_full;
  logic             wr_uart;
  logic [7:0]       w_data;

  uart_tx_arbiter #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .gnt(gnt), .busy(busy), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Client side: pending burst lengths and pending payload bytes
  int         b0[$], b1[$];
  logic [7:0] q0[$], q1[$];
  // Model side: every burst loaded since the last check
  int         m_len0[$], m_len1[$];
  logic [7:0] m_b0[$], m_b1[$];
  int         m_last = 1;
  // Observed
  logic [7:0] cap[$];
  int         cap_cyc[$];
  logic [1:0] gnt_seq[$];
  logic [1:0] prev_gnt = 2'b00;
  int         gnt_cyc = -1;
  int         done_cyc = -1;
  int         ack_cnt[2];
  int         done_cnt[2];
  int         full_pct = 0;
  bit         force_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int c, input int len, input int base);
    logic [7:0] bt;
    if (c == 0) begin b0.push_back(len); m_len0.push_back(len); end
    else        begin b1.push_back(len); m_len1.push_back(len); end
    for (int i = 0; i <= len; i++) begin
      bt = (base >= 0) ? 8'(base + i) : 8'($urandom_range(255));
      if (c == 0) begin q0.push_back(bt); m_b0.push_back(bt); end
      else        begin q1.push_back(bt); m_b1.push_back(bt); end
    end
  endtask

  task automatic begin_cyc();
    req0    = (b0.size() != 0);
    req1    = (b1.size() != 0);
    len0    = (b0.size() != 0) ? LEN_W'(b0[0]) : '0;
    len1    = (b1.size() != 0) ? LEN_W'(b1[0]) : '0;
    data0   = (q0.size() != 0) ? q0[0] : 8'h00;
    data1   = (q1.size() != 0) ? q1[0] : 8'h00;
    tx_full = force_full || (int'($urandom_range(99)) < full_pct);
    #1;
  endtask

  task automatic end_cyc();
    chk("no_wr_when_full", 32'(wr_uart && tx_full), 32'd0);
    if (wr_uart) begin cap.push_back(w_data); cap_cyc.push_back(cyc); end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin gnt_seq.push_back(gnt); gnt_cyc = cyc; end
    prev_gnt = gnt;
    if (ack0) begin
      chk("ack0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin chk("ack0_data", 32'(w_data), 32'(q0[0])); void'(q0.pop_front()); end
      ack_cnt[0]++;
    end
    if (ack1) begin
      chk("ack1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin chk("ack1_data", 32'(w_data), 32'(q1[0])); void'(q1.pop_front()); end
      ack_cnt[1]++;
    end
    if (done0) begin done_cnt[0]++; done_cyc = cyc; if (b0.size() != 0) void'(b0.pop_front()); end
    if (done1) begin done_cnt[1]++; done_cyc = cyc; if (b1.size() != 0) void'(b1.pop_front()); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic tick();
    begin_cyc();
    end_cyc();
  endtask

  task automatic run_all(input int max_cyc);
    int n = 0;
    while ((b0.size() != 0 || b1.size() != 0 || busy) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("run_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  // Transaction-level model: bursts granted round robin, header (if enabled) then payload
  task automatic check_stream(input string tag);
    logic [7:0] exp[$];
    logic [1:0] exp_gnt[$];
    int i0 = 0, i1 = 0, p0 = 0, p1 = 0, c, len;
    while (i0 < m_len0.size() || i1 < m_len1.size()) begin
      if (i0 < m_len0.size() && i1 < m_len1.size()) c = (m_last == 0) ? 1 : 0;
      else c = (i0 < m_len0.size()) ? 0 : 1;
      len = (c == 1) ? m_len1[i1] : m_len0[i0];
      exp_gnt.push_back((c == 1) ? 2'b10 : 2'b01);
`ifdef UART_ARB_HDR_EN
      exp.push_back(8'({3'b101, 1'(c), 4'(len)}));
`endif
      for (int k = 0; k <= len; k++) begin
        if (c == 1) begin exp.push_back(m_b1[p1]); p1++; end
        else        begin exp.push_back(m_b0[p0]); p0++; end
      end
      if (c == 1) i1++; else i0++;
      m_last = c;
    end
    chk({tag, "_count"}, 32'(cap.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk({tag, "_byte"}, 32'(cap[i]), 32'(exp[i]));
    chk({tag, "_grants"}, 32'(gnt_seq.size()), 32'(exp_gnt.size()));
    for (int i = 0; i < exp_gnt.size() && i < gnt_seq.size(); i++)
      chk({tag, "_gnt"}, 32'(gnt_seq[i]), 32'(exp_gnt[i]));
    chk({tag, "_q0_drained"}, 32'(q0.size()), 32'd0);
    chk({tag, "_q1_drained"}, 32'(q1.size()), 32'd0);
    cap.delete(); cap_cyc.delete(); gnt_seq.delete();
    m_len0.delete(); m_len1.delete(); m_b0.delete(); m_b1.delete();
  endtask

  initial begin
    int saved_done1;
    int n;
    logic [7:0] held;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    data0 = 8'h00; data1 = 8'h00; tx_full = 1'b0;
    ack_cnt = '{0, 0}; done_cnt = '{0, 0};
    @(posedge clk); #1;

    // Reset held with req0 asserted: every output quiet
    load(0, 3, 8'h11);
    tick(); tick();
    begin_cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_dones", 32'({done0, done1}), 32'd0);
    end_cyc();
    reset = 1'b0;
    begin_cyc();
    chk("idle_after_release", 32'(gnt), 32'd0);
    end_cyc();
    begin_cyc();
    chk("gnt_after_release", 32'(gnt), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd1);
    end_cyc();

    // Four-byte burst from client 0 with no back-pressure
    run_all(50);
    chk("burst_first_write_at_grant", 32'(cap_cyc.size() != 0 && cap_cyc[0] == gnt_cyc), 32'd1);
    for (int i = 0; i + 1 < cap_cyc.size(); i++)
      chk("burst_consecutive", 32'(cap_cyc[i + 1] - cap_cyc[i]), 32'd1);
    if (cap_cyc.size() != 0)
      chk("done_after_last_write", 32'(done_cyc - cap_cyc[cap_cyc.size() - 1]), 32'd1);
    chk("burst_acks", 32'(ack_cnt[0]), 32'd4);
    chk("burst_dones", 32'(done_cnt[0]), 32'd1);
    check_stream("burst4");

    // Both clients with single-byte bursts: grants alternate
    for (int i = 0; i < 3; i++) begin load(0, 0, -1); load(1, 0, -1); end
    run_all(100);
`ifndef UART_ARB_HDR_EN
    for (int i = 0; i + 1 < cap_cyc.size(); i++)
      chk("rr_gap", 32'(cap_cyc[i + 1] - cap_cyc[i]), 32'd3);
`endif
    check_stream("alternate");

    // Five-cycle tx_full stall in the middle of a 16-byte burst
    load(0, 15, -1);
    n = 0;
    while (cap.size() < 3 && n < 50) begin tick(); n++; end
    chk("stall_reach", 32'(n < 50), 32'd1);
    force_full = 1'b1;
    held = (q0.size() != 0) ? q0[0] : 8'h00;
    for (int i = 0; i < 5; i++) begin
      begin_cyc();
      chk("stall_wr_uart", 32'(wr_uart), 32'd0);
      chk("stall_w_data", 32'(w_data), 32'(held));
      chk("stall_busy", 32'(busy), 32'd1);
      end_cyc();
    end
    force_full = 1'b0;
    run_all(100);
    check_stream("stall");

    // Reset on the second byte of a 16-byte burst from client 1
    load(1, 15, -1);
    n = 0;
    while (cap.size() < 1 && n < 50) begin tick(); n++; end
    saved_done1 = done_cnt[1];
    reset = 1'b1;
    begin_cyc();
    chk("midrst_wr_uart", 32'(wr_uart), 32'd0);
    chk("midrst_done1", 32'(done1), 32'd0);
    chk("midrst_ack1", 32'(ack1), 32'd0);
    end_cyc();
    reset = 1'b0;
    b1.delete(); q1.delete();
    cap.delete(); cap_cyc.delete(); gnt_seq.delete();
    m_len0.delete(); m_len1.delete(); m_b0.delete(); m_b1.delete();
    m_last = 1;
    begin_cyc();
    chk("midrst_gnt_cleared", 32'(gnt), 32'd0);
    chk("midrst_busy_cleared", 32'(busy), 32'd0);
    end_cyc();
    chk("midrst_no_done", 32'(done_cnt[1]), 32'(saved_done1));
    load(0, 1, -1); load(1, 1, -1);
    run_all(100);
    check_stream("after_reset");

    // Randomised bursts and back-pressure
    done_cnt = '{0, 0};
    full_pct = 30;
    for (int i = 0; i < 4; i++) begin
      load(0, int'($urandom_range(15)), -1);
      load(1, int'($urandom_range(15)), -1);
    end
    run_all(2000);
    chk("rand_done0", 32'(done_cnt[0]), 32'd4);
    chk("rand_done1", 32'(done_cnt[1]), 32'd4);
    check_stream("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the transmit side of `uart_with_parity` between two byte-stream clients. Each client requests a burst of 1–16 bytes. The arbiter grants one client for the whole burst and streams its bytes into the UART transmit FIFO via `wr_uart`/`w_data`, honouring `tx_full`. It then releases the grant and rotates priority.

## Interface
Parameters:
- `LEN_W`, default 4: width of burst length field; burst size = len+1 bytes (1..2^LEN_W).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  client burst request; must be held until that client's `done` pulse.
- `len0`, `len1`  in  LEN_W  burst length minus one; sampled in the grant cycle only.
- `data0`, `data1`  in  8  current byte of the client; must be stable while granted and change only after `ack`.
- `ack0`, `ack1`  out  1  one-cycle pulse: the byte on `dataN` was written this cycle.
- `done0`, `done1`  out  1  one-cycle pulse after the burst's last byte.
- `gnt`  out  2  one-hot grant (bit N = client N), 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `tx_full`  in  1  from UART; no write may be issued while high.
- `wr_uart`  out  1  UART FIFO write strobe.
- `w_data`  out  8  byte to UART.

## Operation
- States: IDLE, HDR (only with the macro), SEND, DONE. State, `gnt`, counter `cnt`, and the `last` pointer are registered. `wr_uart`, `w_data`, and `ack*` are combinational from state and `tx_full`.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the client that is not `last`.
  - On grant: load `cnt` ← `lenN`, set `gnt`, go to HDR (macro) or SEND.
- SEND:
  - `wr_uart` = !`tx_full`.
  - `w_data` = data of the granted client, else 8'h00.
  - `ackN` = `wr_uart` and granted client N.
  - On a write with `cnt`==0, go to DONE; on a write otherwise, decrement `cnt`.
  - With `tx_full` high, stall and hold state.
- DONE:
  - `doneN` pulses for the granted client.
  - `last` ← granted id, `gnt` ← 0, go to IDLE.
- Dropping `reqN` mid-burst is ignored; the burst completes.
- `len` changes after grant are ignored.
- `cnt` is LEN_W bits. It never wraps, because the decrement is suppressed at 0.
- Reset values: state IDLE, `gnt`=0, `cnt`=0, `last`=1 (client 0 wins the first tie), and `busy`, `wr_uart`, `ack*`, `done*` all 0, `w_data`=0.
- Reset mid-burst:
  - Abandon the burst; no `done` pulse.
  - `wr_uart` is forced 0 in any cycle where `reset` is high.

## Timing
- `req` is sampled high at edge n, giving `gnt` and `busy` high from n+1.
- Without the macro, the first `wr_uart` occurs in cycle n+1 if `tx_full` is low.
- Throughput is one byte per cycle while `tx_full` is low. An L-byte burst with no stalls occupies L SEND cycles + 1 DONE + 1 IDLE.
- `wr_uart` depends combinationally on the same-cycle `tx_full`, so a FIFO going full is never overrun.
- Back-to-back bursts: the next grant is issued in the IDLE cycle after DONE. The minimum gap is 2 cycles without a write.

## Configuration
- `UART_ARB_HDR_EN` defined:
  - After grant, enter HDR and emit one header byte before the payload: `w_data` = {3'b101, id, len}, e.g. client 0 with len 3 sends 8'hA3 and client 1 with len 3 sends 8'hB3.
  - The header obeys `tx_full` like payload bytes.
  - `ack` is not pulsed for the header.
  - First payload write is at n+2 at the earliest.
- Undefined: the HDR state does not exist, and the payload starts at n+1.

## Test plan
- Reset with `req0`=1 asserted → all outputs 0. After reset release, `gnt`=2'b01 the next cycle.
- `req0`, `len0`=3, data 0x11..0x14, `tx_full`=0 → four consecutive `wr_uart` pulses with `w_data` 0x11, 0x12, 0x13, 0x14 and four `ack0` pulses. `done0` follows one cycle after the last write.
- `req0` and `req1` held with `len`=0 → grants alternate 01, 10, 01, … Each burst is exactly one write.
- `tx_full` raised for 5 cycles mid-burst → `wr_uart`=0 throughout, `cnt` and `w_data` held. The burst resumes with no byte lost or duplicated.
- Reset asserted on the 2nd byte of a 16-byte burst → `wr_uart`=0 in the reset cycle and no `done1`. An idle-state restart follows, with `last`=1.
- With `UART_ARB_HDR_EN`, `req1`, `len1`=2 → bytes 0xB2 then three payload bytes. `ack1` pulses only 3 times.
